// File: rtl/countdown_timer_autoreload_pkg.sv
// Shared timer definitions: state encoding and default count width.
// The up-counter bench imports the same package.
package cid_timer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage : cid_timer_pkg

// File: rtl/countdown_timer_autoreload_if.sv
// Control/status bundle for the down-counting timer.
// Handshake: there is no valid/ready pair. load, stop and en are level
// strobes sampled on every rising clk edge. All outputs are registered.
interface countdown_timer_autoreload_if
  import cid_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             en;
  logic             auto_reload;
  logic             stop;
  logic [WIDTH-1:0] value;
  logic             expire;
  logic             running;
  logic             paused;
  state_e           state_dbg;
  logic [WIDTH-1:0] reload_dbg;

  // master drives control and watches status; slave is the timer itself
  modport master (
    output load, load_value, en, auto_reload, stop,
    input  value, expire, running, paused, state_dbg, reload_dbg
  );

  modport slave (
    input  load, load_value, en, auto_reload, stop,
    output value, expire, running, paused, state_dbg, reload_dbg
  );

endinterface : countdown_timer_autoreload_if

// File: rtl/countdown_timer_autoreload.sv
// Down-counting timer with a one-cycle expire pulse and an optional reload.
// Priority on each edge: stop > load > count.
module countdown_timer_autoreload
  import cid_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                          clk,
  input logic                          rst,
  countdown_timer_autoreload_if.slave  bus
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      value_q  <= ZERO;
      reload_q <= ZERO;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    reload_d = reload_q;
    expire_d = 1'b0;

    if (bus.stop) begin
      state_d = ST_IDLE;
      value_d = ZERO;
    end else if (bus.load) begin
      // The load cycle itself never decrements; it only arms the count.
      reload_d = bus.load_value;
      value_d  = bus.load_value;
      if (bus.load_value == ZERO) begin
        state_d = ST_IDLE;
      end else if (bus.en) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_PAUSE;
      end
    end else begin
      case (state_q)
        ST_RUN, ST_PAUSE: begin
          if (!bus.en) begin
            state_d = ST_PAUSE;
          end else if (value_q != ONE) begin
            // value is never 0 while active, so this cannot wrap
            value_d = value_q - ONE;
            state_d = ST_RUN;
          end else begin
            expire_d = 1'b1;
            if (bus.auto_reload) begin
              value_d = reload_q;
              state_d = ST_RUN;
            end else begin
              value_d = ZERO;
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.value      = value_q;
  assign bus.expire     = expire_q;
  assign bus.running    = (state_q != ST_IDLE);
  assign bus.paused     = (state_q == ST_PAUSE);
  assign bus.state_dbg  = state_q;
  assign bus.reload_dbg = reload_q;

endmodule : countdown_timer_autoreload

// File: tb/tb_countdown_timer_autoreload.sv
// Scoreboarded bench for countdown_timer_autoreload: each driven cycle pushes
// its hand-derived expected status, popped and compared one tick after the edge.
module tb_countdown_timer_autoreload;
  import cid_timer_pkg::*;

  localparam int W  = 8;
  localparam int VW = 2 + W + W + 3;

  logic clk;
  logic rst;

  countdown_timer_autoreload_if #(.WIDTH(W)) tif ();

  countdown_timer_autoreload #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_miss;
  logic [VW-1:0] exp_q[$];

  function automatic logic [VW-1:0] pack_exp(input logic [W-1:0] rld,
                                             input logic [W-1:0] val,
                                             input logic ex, input logic run,
                                             input logic pau);
    logic [1:0] st;
    st = pau ? 2'd2 : (run ? 2'd1 : 2'd0);
    return {st, rld, val, ex, run, pau};
  endfunction

  function automatic logic [VW-1:0] observed();
    return {tif.state_dbg, tif.reload_dbg, tif.value, tif.expire, tif.running, tif.paused};
  endfunction

  task automatic check_vec(input string tag, input logic [VW-1:0] obs,
                           input logic [VW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got st=%0d rld=%0d val=%0d ex=%b run=%b pau=%b, want st=%0d rld=%0d val=%0d ex=%b run=%b pau=%b",
               tag, obs[VW-1 -: 2], obs[VW-3 -: W], obs[W+2 : 3], obs[2], obs[1], obs[0],
               exp[VW-1 -: 2], exp[VW-3 -: W], exp[W+2 : 3], exp[2], exp[1], exp[0]);
    end
  endtask

  // driver: apply one cycle of inputs and queue the status expected after the edge
  task automatic step(input string tag, input logic ld, input logic [W-1:0] lv,
                      input logic e, input logic ar, input logic sp,
                      input logic [W-1:0] x_rld, input logic [W-1:0] x_val,
                      input logic x_ex, input logic x_run, input logic x_pau);
    logic [VW-1:0] exp;
    tif.load        = ld;
    tif.load_value  = lv;
    tif.en          = e;
    tif.auto_reload = ar;
    tif.stop        = sp;
    exp_q.push_back(pack_exp(x_rld, x_val, x_ex, x_run, x_pau));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check_vec(tag, observed(), exp);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1;
    tif.load = 1'b0; tif.load_value = '0; tif.en = 1'b0;
    tif.auto_reload = 1'b0; tif.stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset", observed(), pack_exp(8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    // idle ignores en
    step("idle_en", 0, 8'd0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0);

    // one-shot from 3
    step("os_load", 1, 8'd3, 1, 0, 0, 8'd3, 8'd3, 0, 1, 0);
    step("os_2",    0, 8'd0, 1, 0, 0, 8'd3, 8'd2, 0, 1, 0);
    step("os_1",    0, 8'd0, 1, 0, 0, 8'd3, 8'd1, 0, 1, 0);
    step("os_0",    0, 8'd0, 1, 0, 0, 8'd3, 8'd0, 1, 0, 0);
    step("os_after",0, 8'd0, 1, 0, 0, 8'd3, 8'd0, 0, 0, 0);

    // periodic from 4, 12 counting cycles -> 3 pulses
    step("ar_load", 1, 8'd4, 1, 1, 0, 8'd4, 8'd4, 0, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      if (k % 4 == 0) step("ar_tick", 0, 8'd0, 1, 1, 0, 8'd4, 8'd4, 1, 1, 0);
      else            step("ar_cnt",  0, 8'd0, 1, 1, 0, 8'd4, 8'(4 - (k % 4)), 0, 1, 0);
    end

    // pause and resume
    step("pz_load", 1, 8'd5, 1, 0, 0, 8'd5, 8'd5, 0, 1, 0);
    step("pz_4",    0, 8'd0, 1, 0, 0, 8'd5, 8'd4, 0, 1, 0);
    step("pz_3",    0, 8'd0, 1, 0, 0, 8'd5, 8'd3, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      step("pz_hold", 0, 8'd0, 0, 0, 0, 8'd5, 8'd3, 0, 1, 1);
    step("pz_2",    0, 8'd0, 1, 0, 0, 8'd5, 8'd2, 0, 1, 0);
    step("pz_1",    0, 8'd0, 1, 0, 0, 8'd5, 8'd1, 0, 1, 0);
    step("pz_0",    0, 8'd0, 1, 0, 0, 8'd5, 8'd0, 1, 0, 0);

    // stop beats load; reload register untouched by stop
    step("st_load", 1, 8'd7, 1, 1, 0, 8'd7, 8'd7, 0, 1, 0);
    step("st_6",    0, 8'd0, 1, 1, 0, 8'd7, 8'd6, 0, 1, 0);
    step("st_both", 1, 8'd9, 1, 1, 1, 8'd7, 8'd0, 0, 0, 0);
    step("ld_zero", 1, 8'd0, 1, 1, 0, 8'd0, 8'd0, 0, 0, 0);
    step("ld_zero2",0, 8'd0, 1, 1, 0, 8'd0, 8'd0, 0, 0, 0);

    // load beats the terminal tick
    step("lt_load", 1, 8'd2, 1, 1, 0, 8'd2, 8'd2, 0, 1, 0);
    step("lt_1",    0, 8'd0, 1, 1, 0, 8'd2, 8'd1, 0, 1, 0);
    step("lt_reld", 1, 8'd6, 1, 1, 0, 8'd6, 8'd6, 0, 1, 0);
    step("lt_5",    0, 8'd0, 1, 1, 0, 8'd6, 8'd5, 0, 1, 0);
    // load with en low goes straight to PAUSE
    step("lp_load", 1, 8'd5, 0, 1, 0, 8'd5, 8'd5, 0, 1, 1);

    // reload of 1: expire every cycle
    step("r1_load", 1, 8'd1, 1, 1, 0, 8'd1, 8'd1, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      step("r1_tick", 0, 8'd0, 1, 1, 0, 8'd1, 8'd1, 1, 1, 0);

    // random periodic runs
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(2, 9);
      step("rn_load", 1, 8'(n), 1, 1, 0, 8'(n), 8'(n), 0, 1, 0);
      for (int k = 1; k <= 2 * n + 1; k++) begin
        if (k % n == 0) step("rn_tick", 0, 8'd0, 1, 1, 0, 8'(n), 8'(n), 1, 1, 0);
        else            step("rn_cnt",  0, 8'd0, 1, 1, 0, 8'(n), 8'(n - (k % n)), 0, 1, 0);
      end
    end

    // asynchronous reset mid-count
    step("rs_load", 1, 8'd8, 1, 0, 0, 8'd8, 8'd8, 0, 1, 0);
    step("rs_7",    0, 8'd0, 1, 0, 0, 8'd8, 8'd7, 0, 1, 0);
    step("rs_6",    0, 8'd0, 1, 0, 0, 8'd8, 8'd6, 0, 1, 0);
    step("rs_5",    0, 8'd0, 1, 0, 0, 8'd8, 8'd5, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check_vec("rs_async", observed(), pack_exp(8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      step("rs_idle", 0, 8'd0, 1, 1, 0, 8'd0, 8'd0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL leftover: %0d entries remain, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_countdown_timer_autoreload
